// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and load-kind encoding for the W stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_LB   = 6'b100000;
   localparam logic [5:0] OP_LBU  = 6'b100100;
   localparam logic [5:0] OP_LH   = 6'b100001;
   localparam logic [5:0] OP_LHU  = 6'b100101;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] FN_JALR = 6'b001001;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [2:0] {
      LK_W  = 3'd0,
      LK_B  = 3'd1,
      LK_BU = 3'd2,
      LK_H  = 3'd3,
      LK_HU = 3'd4
   } load_kind_t;

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage bundle: MEM/WB inputs, ID read ports, forward and retire outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the pipeline advances every cycle.
interface wb_regfile_if #(
   parameter int DATA_W   = 32,
   parameter int RETIRE_W = 32
);
   logic [5:0]          op_w;
   logic [5:0]          func_w;
   logic [DATA_W-1:0]   pc_w;
   logic                regwrite_w;
   logic [4:0]          wa_w;
   logic [DATA_W-1:0]   aluout_w;
   logic [DATA_W-1:0]   memrd_w;
   logic [4:0]          ra1;
   logic [4:0]          ra2;
   logic [DATA_W-1:0]   rd1;
   logic [DATA_W-1:0]   rd2;
   logic                fwd_we;
   logic [4:0]          fwd_wa;
   logic [DATA_W-1:0]   fwd_wd;
   logic [RETIRE_W-1:0] retire_cnt;

   modport master (
      output op_w, func_w, pc_w, regwrite_w, wa_w, aluout_w, memrd_w, ra1, ra2,
      input  rd1, rd2, fwd_we, fwd_wa, fwd_wd, retire_cnt
   );

   modport slave (
      input  op_w, func_w, pc_w, regwrite_w, wa_w, aluout_w, memrd_w, ra1, ra2,
      output rd1, rd2, fwd_we, fwd_wa, fwd_wd, retire_cnt
   );
endinterface

// File: rtl/wb_load_ext.sv
// Sub-word load extraction: picks byte/half from the raw word and extends it.
// Latency: combinational.
// Backpressure: none.
module wb_load_ext
   import mips_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  load_kind_t  kind,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select; halfword uses addr[1] only, so a misaligned half is silently truncated.
   always_comb begin
      case (addr)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr[1] ? word[31:16] : word[15:0];
   end

   // Sign/zero extension by load kind.
   always_comb begin
      case (kind)
         LK_B:    data = {{24{byte_sel[7]}}, byte_sel};
         LK_BU:   data = {24'd0, byte_sel};
         LK_H:    data = {{16{half_sel[15]}}, half_sel};
         LK_HU:   data = {16'd0, half_sel};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: forms final write data, commits to the 32x32 register file, bypassed ID reads, retire count.
// Latency: write data/reads/forward are combinational; register and counter update on the next rising edge.
// Backpressure: none. Optional WB_LOG_EN prints one line per committed write (simulation only).
module wb_regfile
   import mips_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NREG     = 32,
   parameter int RETIRE_W = 32
) (
   input  logic         clk,
   input  logic         reset,
   wb_regfile_if.slave  wb
);

   logic [DATA_W-1:0]   regs [NREG];
   logic [RETIRE_W-1:0] retire_q;
   load_kind_t          kind;
   logic                is_load;
   logic                is_link;
   logic [DATA_W-1:0]   ext_d;
   logic [DATA_W-1:0]   wd;
   logic                we;

   // Decode the W instruction into load kind and link-type (jal/jalr).
   always_comb begin
      kind    = LK_W;
      is_load = 1'b1;
      case (wb.op_w)
         OP_LW:   kind = LK_W;
         OP_LB:   kind = LK_B;
         OP_LBU:  kind = LK_BU;
         OP_LH:   kind = LK_H;
         OP_LHU:  kind = LK_HU;
         default: is_load = 1'b0;
      endcase
      is_link = (wb.op_w == OP_JAL) || (wb.op_w == 6'd0 && wb.func_w == FN_JALR);
   end

   wb_load_ext u_load_ext (
      .word (wb.memrd_w),
      .addr (wb.aluout_w[1:0]),
      .kind (kind),
      .data (ext_d)
   );

   // Final write-data mux: link address beats load data beats ALU result.
   always_comb begin
      if (is_link)
         wd = wb.pc_w + DATA_W'(8);
      else if (is_load)
         wd = ext_d;
      else
         wd = wb.aluout_w;
   end

   assign we            = wb.regwrite_w && (wb.wa_w != REG_ZERO);
   assign wb.fwd_we     = we;
   assign wb.fwd_wa     = wb.wa_w;
   assign wb.fwd_wd     = wd;
   assign wb.retire_cnt = retire_q;

   // Read ports: $0 is zero, same-cycle write wins over the stored value.
   always_comb begin
      if (wb.ra1 == REG_ZERO)
         wb.rd1 = '0;
      else if (we && wb.ra1 == wb.wa_w)
         wb.rd1 = wd;
      else
         wb.rd1 = regs[wb.ra1];

      if (wb.ra2 == REG_ZERO)
         wb.rd2 = '0;
      else if (we && wb.ra2 == wb.wa_w)
         wb.rd2 = wd;
      else
         wb.rd2 = regs[wb.ra2];
   end

   // Register commit; reset clears the whole file and drops any write in that cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (we) begin
         regs[wb.wa_w] <= wd;
      end
   end

   // Retired-instruction counter; bubbles (op=0, func=0) are not counted, wraps freely.
   always_ff @(posedge clk) begin
      if (reset)
         retire_q <= '0;
      else if ({wb.op_w, wb.func_w} != 12'd0)
         retire_q <= retire_q + RETIRE_W'(1);
   end

`ifdef WB_LOG_EN
   // Commit trace for simulation runs.
   always_ff @(posedge clk) begin
      if (!reset && we)
         $display("@%h: $%d <= %h", wb.pc_w, wb.wa_w, wd);
   end
`else
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised and directed bench for wb_regfile against a behavioural register-file model.
// Latency: model commits on each rising edge, combinational outputs checked mid-cycle.
// Backpressure: none.
module tb_wb_regfile;

   localparam logic [5:0] T_LW   = 6'b100011;
   localparam logic [5:0] T_LB   = 6'b100000;
   localparam logic [5:0] T_LBU  = 6'b100100;
   localparam logic [5:0] T_LH   = 6'b100001;
   localparam logic [5:0] T_LHU  = 6'b100101;
   localparam logic [5:0] T_JAL  = 6'b000011;
   localparam logic [5:0] T_ADDI = 6'b001000;
   localparam logic [5:0] T_JALR = 6'b001001;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_pass = 0;

   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;

   wb_regfile_if #(.DATA_W(32), .RETIRE_W(32)) bus ();
   wb_regfile_if #(.DATA_W(32), .RETIRE_W(4))  bus_s ();

   assign bus_s.op_w       = bus.op_w;
   assign bus_s.func_w     = bus.func_w;
   assign bus_s.pc_w       = bus.pc_w;
   assign bus_s.regwrite_w = bus.regwrite_w;
   assign bus_s.wa_w       = bus.wa_w;
   assign bus_s.aluout_w   = bus.aluout_w;
   assign bus_s.memrd_w    = bus.memrd_w;
   assign bus_s.ra1        = bus.ra1;
   assign bus_s.ra2        = bus.ra2;

   wb_regfile #(.DATA_W(32), .NREG(32), .RETIRE_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (bus)
   );

   wb_regfile #(.DATA_W(32), .NREG(32), .RETIRE_W(4)) dut_small (
      .clk   (clk),
      .reset (reset),
      .wb    (bus_s)
   );

   always #5 clk = ~clk;

   // Expected write data straight from the ISA semantics.
   function automatic logic [31:0] exp_wd();
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      int          sh;
      w = bus.memrd_w;
      case (bus.op_w)
         T_LW: return w;
         T_LB, T_LBU: begin
            sh = int'(bus.aluout_w[1:0]) * 8;
            b  = 8'(w >> sh);
            return (bus.op_w == T_LB) ? 32'($signed(b)) : {24'd0, b};
         end
         T_LH, T_LHU: begin
            sh = int'(bus.aluout_w[1]) * 16;
            h  = 16'(w >> sh);
            return (bus.op_w == T_LH) ? 32'($signed(h)) : {16'd0, h};
         end
         T_JAL: return bus.pc_w + 32'd8;
         6'd0: return (bus.func_w == T_JALR) ? bus.pc_w + 32'd8 : bus.aluout_w;
         default: return bus.aluout_w;
      endcase
   endfunction

   function automatic logic exp_we();
      return bus.regwrite_w && bus.wa_w != 5'd0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [4:0] ra);
      if (ra == 5'd0) return 32'd0;
      if (exp_we() && bus.wa_w == ra) return exp_wd();
      return m_regs[ra];
   endfunction

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] pc,
                        input logic rw, input logic [4:0] wa, input logic [31:0] alu,
                        input logic [31:0] mem);
      bus.op_w = op; bus.func_w = fn; bus.pc_w = pc; bus.regwrite_w = rw;
      bus.wa_w = wa; bus.aluout_w = alu; bus.memrd_w = mem;
   endtask

   task automatic idle();
      drive(6'd0, 6'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
   endtask

   // Advance one clock, updating the model with what the DUT sees at the edge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_cnt = 32'd0;
      end else begin
         if (exp_we()) m_regs[bus.wa_w] = exp_wd();
         if ({bus.op_w, bus.func_w} != 12'd0) m_cnt = m_cnt + 32'd1;
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; idle(); tick(); reset = 1'b0; #1;
   endtask

   task automatic test_reset();
      do_reset();
      bus.ra1 = 5'd5; bus.ra2 = 5'd31; #1;
      n_chk++; if (bus.rd1 !== 32'd0) $display("FAIL reset_rd1 got=%h exp=0", bus.rd1); else n_pass++;
      n_chk++; if (bus.rd2 !== 32'd0) $display("FAIL reset_rd2 got=%h exp=0", bus.rd2); else n_pass++;
      n_chk++; if (bus.retire_cnt !== 32'd0) $display("FAIL reset_cnt got=%0d exp=0", bus.retire_cnt); else n_pass++;
      for (int i = 1; i < 32; i++) begin
         drive(T_ADDI, 6'($urandom), 32'h100, 1'b1, 5'(i), $urandom | 32'h1, 32'd0);
         tick();
      end
      idle(); bus.ra1 = 5'd17; #1;
      n_chk++; if (bus.rd1 !== m_regs[17] || m_regs[17] == 32'd0)
         $display("FAIL preload_r17 got=%h exp=%h", bus.rd1, m_regs[17]); else n_pass++;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         bus.ra1 = 5'(i); bus.ra2 = 5'(31 - i); #1;
         n_chk++; if (bus.rd1 !== 32'd0) $display("FAIL rereset_rd1[%0d] got=%h exp=0", i, bus.rd1); else n_pass++;
         n_chk++; if (bus.rd2 !== 32'd0) $display("FAIL rereset_rd2[%0d] got=%h exp=0", 31 - i, bus.rd2); else n_pass++;
      end
   endtask

   task automatic test_bypass();
      drive(T_ADDI, 6'd0, 32'h200, 1'b1, 5'd8, 32'h1234_5678, 32'd0);
      bus.ra1 = 5'd8; bus.ra2 = 5'd8; #1;
      n_chk++; if (bus.rd1 !== 32'h1234_5678) $display("FAIL bypass_rd1 got=%h exp=12345678", bus.rd1); else n_pass++;
      n_chk++; if (bus.rd2 !== bus.rd1) $display("FAIL bypass_same_port got=%h exp=%h", bus.rd2, bus.rd1); else n_pass++;
      n_chk++; if (bus.fwd_we !== 1'b1 || bus.fwd_wa !== 5'd8)
         $display("FAIL bypass_fwd got=%b/%0d exp=1/8", bus.fwd_we, bus.fwd_wa); else n_pass++;
      tick(); idle(); #1;
      n_chk++; if (bus.rd1 !== 32'h1234_5678) $display("FAIL commit_r8 got=%h exp=12345678", bus.rd1); else n_pass++;
      drive(T_ADDI, 6'd0, 32'h204, 1'b1, 5'd0, 32'hDEAD_BEEF, 32'd0);
      bus.ra1 = 5'd0; #1;
      n_chk++; if (bus.fwd_we !== 1'b0) $display("FAIL zero_fwd_we got=%b exp=0", bus.fwd_we); else n_pass++;
      n_chk++; if (bus.rd1 !== 32'd0) $display("FAIL zero_rd_pre got=%h exp=0", bus.rd1); else n_pass++;
      tick(); idle(); #1;
      n_chk++; if (bus.rd1 !== 32'd0) $display("FAIL zero_rd_post got=%h exp=0", bus.rd1); else n_pass++;
   endtask

   task automatic test_loads();
      logic [5:0]  ops [5] = '{T_LB, T_LBU, T_LH, T_LHU, T_LW};
      logic [1:0]  ads [5] = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd1};
      logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF, 32'h80FF_7F01};
      for (int i = 0; i < 5; i++) begin
         drive(ops[i], 6'd0, 32'h300, 1'b1, 5'd10, {30'h100, ads[i]}, 32'h80FF_7F01); #1;
         n_chk++; if (bus.fwd_wd !== exps[i]) $display("FAIL load_dir[%0d] got=%h exp=%h", i, bus.fwd_wd, exps[i]); else n_pass++;
         tick();
      end
      for (int i = 0; i < 40; i++) begin
         drive(ops[$urandom_range(0, 4)], 6'd0, 32'h400, 1'b1, 5'(1 + $urandom_range(0, 30)), $urandom, $urandom); #1;
         n_chk++; if (bus.fwd_wd !== exp_wd()) $display("FAIL load_rnd[%0d] got=%h exp=%h", i, bus.fwd_wd, exp_wd()); else n_pass++;
         tick();
      end
      idle();
   endtask

   task automatic test_link();
      drive(T_JAL, 6'd0, 32'h0000_3000, 1'b1, 5'd31, 32'h55, 32'h66); tick();
      drive(6'd0, T_JALR, 32'h0000_4444, 1'b1, 5'd5, 32'h77, 32'h88); tick();
      idle(); bus.ra1 = 5'd31; bus.ra2 = 5'd5; #1;
      n_chk++; if (bus.rd1 !== 32'h0000_3008) $display("FAIL jal_r31 got=%h exp=00003008", bus.rd1); else n_pass++;
      n_chk++; if (bus.rd2 !== 32'h0000_444C) $display("FAIL jalr_r5 got=%h exp=0000444c", bus.rd2); else n_pass++;
   endtask

   task automatic test_retire();
      do_reset();
      drive(T_ADDI, 6'd0, 32'h10, 1'b0, 5'd0, 32'd0, 32'd0); tick();
      idle(); tick();
      drive(6'd0, 6'h20, 32'h14, 1'b1, 5'd3, 32'd9, 32'd0); tick();
      idle(); tick();
      drive(T_LW, 6'd0, 32'h18, 1'b1, 5'd4, 32'd0, 32'h1); tick();
      idle(); #1;
      n_chk++; if (bus.retire_cnt !== 32'd3) $display("FAIL retire3 got=%0d exp=3", bus.retire_cnt); else n_pass++;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(T_ADDI, 6'd0, 32'h20, 1'b0, 5'd0, 32'd0, 32'd0); tick();
      end
      n_chk++; if (bus_s.retire_cnt !== 4'd15) $display("FAIL wrap_pre got=%0d exp=15", bus_s.retire_cnt); else n_pass++;
      tick(); idle(); #1;
      n_chk++; if (bus_s.retire_cnt !== 4'd0) $display("FAIL wrap_post got=%0d exp=0", bus_s.retire_cnt); else n_pass++;
      n_chk++; if (bus.retire_cnt !== 32'd16) $display("FAIL wide_cnt got=%0d exp=16", bus.retire_cnt); else n_pass++;
   endtask

   task automatic test_reset_write();
      reset = 1'b1;
      drive(T_ADDI, 6'd0, 32'h0000_3000, 1'b1, 5'd9, 32'hCAFE_F00D, 32'd0); tick();
      reset = 1'b0; idle(); bus.ra1 = 5'd9; #1;
      n_chk++; if (bus.rd1 !== 32'd0) $display("FAIL rstwr_r9 got=%h exp=0", bus.rd1); else n_pass++;
      n_chk++; if (bus.retire_cnt !== 32'd0) $display("FAIL rstwr_cnt got=%0d exp=0", bus.retire_cnt); else n_pass++;
   endtask

   task automatic test_random();
      logic [5:0] op_tab [8] = '{6'd0, T_LW, T_LB, T_LBU, T_LH, T_LHU, T_JAL, T_ADDI};
      logic [5:0] op, fn;
      logic [4:0] wa;
      for (int i = 0; i < 200; i++) begin
         op = op_tab[$urandom_range(0, 7)];
         fn = 6'($urandom);
         if (op == 6'd0) fn = ($urandom_range(0, 2) == 0) ? 6'd0 : (($urandom_range(0, 1) == 0) ? T_JALR : fn);
         wa = 5'($urandom);
         drive(op, fn, $urandom, ($urandom_range(0, 3) != 0), wa, $urandom, $urandom);
         bus.ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
         bus.ra2 = ($urandom_range(0, 3) == 0) ? bus.ra1 : 5'($urandom);
         #1;
         n_chk++; if (bus.rd1 !== exp_rd(bus.ra1)) $display("FAIL rnd_rd1[%0d] got=%h exp=%h", i, bus.rd1, exp_rd(bus.ra1)); else n_pass++;
         n_chk++; if (bus.rd2 !== exp_rd(bus.ra2)) $display("FAIL rnd_rd2[%0d] got=%h exp=%h", i, bus.rd2, exp_rd(bus.ra2)); else n_pass++;
         n_chk++; if (bus.fwd_we !== exp_we()) $display("FAIL rnd_fwd_we[%0d] got=%b exp=%b", i, bus.fwd_we, exp_we()); else n_pass++;
         n_chk++; if (bus.fwd_wd !== exp_wd()) $display("FAIL rnd_fwd_wd[%0d] got=%h exp=%h", i, bus.fwd_wd, exp_wd()); else n_pass++;
         tick();
         n_chk++; if (bus.retire_cnt !== m_cnt) $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, bus.retire_cnt, m_cnt); else n_pass++;
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      bus.ra1 = 5'd0; bus.ra2 = 5'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 32'd0;
      test_reset();
      test_bypass();
      test_loads();
      test_link();
      test_retire();
      test_reset_write();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
